// File: rtl/memory_responder_if.sv
// memory_responder_if
// Byte-wide memory port between the CPU memory controller (master) and the
// memory responder (slave). One byte moves per cycle.
//   address      : 32-bit byte address, driven by the master
//   write_data   : byte to store, driven by the master
//   write_enable : store strobe, driven by the master
//   read_data    : registered read byte, driven by the slave
interface memory_responder_if;
  logic [31:0] address;
  logic [7:0]  write_data;
  logic        write_enable;
  logic [7:0]  read_data;

  modport master (
    output address,
    output write_data,
    output write_enable,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data,
    input  write_enable,
    output read_data
  );
endinterface

// File: rtl/memory_responder.sv
// memory_responder
// Far end of the CPU memory port: a byte RAM mapped at address 0, a 16-byte
// MMIO window (LED register, free-running timer, status) and a sticky flag
// that records any access falling outside both regions. Every cycle is an
// access: the presented address is always decoded and read.
//
// Optional feature: define MEMORY_RESPONDER_TIMER_EN to build the 32-bit timer
// and its snapshot latch (MMIO offsets 0x4-0x7). Without it those offsets
// read 0x00.
//
// Ports:
//   clk            : clock, all state changes on the rising edge
//   rst            : asynchronous active-low reset
//   bus            : memory_responder_if slave (address, write_data,
//                    write_enable in; registered read_data out)
//   leds           : LED register contents
//   illegal_access : sticky illegal-access flag, cleared via STATUS
module memory_responder #(
  parameter int          RAM_ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE      = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  memory_responder_if.slave  bus,
  output logic [7:0]         leds,
  output logic               illegal_access
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_TIMER0 = 4'h4;
  localparam logic [3:0] OFF_TIMER1 = 4'h5;
  localparam logic [3:0] OFF_TIMER2 = 4'h6;
  localparam logic [3:0] OFF_TIMER3 = 4'h7;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  logic [7:0]                ram [RAM_DEPTH];
  logic                      is_ram;
  logic                      is_mmio;
  logic [3:0]                offset;
  logic [RAM_ADDR_WIDTH-1:0] ram_index;
  logic [7:0]                read_next;

  // RAM occupies every address whose bits above the RAM index are zero.
  assign is_ram    = (bus.address >> RAM_ADDR_WIDTH) == 32'd0;
  assign is_mmio   = bus.address[31:4] == MMIO_BASE[31:4];
  assign offset    = bus.address[3:0];
  assign ram_index = bus.address[RAM_ADDR_WIDTH-1:0];

`ifdef MEMORY_RESPONDER_TIMER_EN
  logic [31:0] timer;
  logic [31:0] timer_latch;

  // Reading TIMER0 snapshots the whole pre-increment count so the following
  // reads of TIMER1-3 assemble a coherent 32-bit value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer       <= 32'd0;
      timer_latch <= 32'd0;
    end else begin
      timer <= timer + 32'd1;
      if (is_mmio && offset == OFF_TIMER0) begin
        timer_latch <= timer;
      end
    end
  end
`endif

  // Read data for the presented address, taken from pre-edge state so a
  // same-cycle write returns the old byte.
  always_comb begin
    read_next = 8'h00;
    if (is_ram) begin
      read_next = ram[ram_index];
    end else if (is_mmio) begin
      case (offset)
        OFF_LED:    read_next = leds;
`ifdef MEMORY_RESPONDER_TIMER_EN
        OFF_TIMER0: read_next = timer[7:0];
        OFF_TIMER1: read_next = timer_latch[15:8];
        OFF_TIMER2: read_next = timer_latch[23:16];
        OFF_TIMER3: read_next = timer_latch[31:24];
`endif
        OFF_STATUS: read_next = {7'd0, illegal_access};
        default:    read_next = 8'h00;
      endcase
    end
  end

  // The RAM write sits in the reset's else branch so a store presented while
  // reset is held never lands; the RAM itself is never cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.read_data  <= 8'h00;
      leds           <= 8'h00;
      illegal_access <= 1'b0;
    end else begin
      bus.read_data <= read_next;
      if (!is_ram && !is_mmio) begin
        illegal_access <= 1'b1;
      end else if (bus.write_enable) begin
        if (is_ram) begin
          ram[ram_index] <= bus.write_data;
        end else if (offset == OFF_LED) begin
          leds <= bus.write_data;
        end else if (offset == OFF_STATUS && bus.write_data[0]) begin
          illegal_access <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
// Randomized and directed stimulus for memory_responder, checked against a
// behavioural model of the memory map (byte array, LED byte, sticky flag,
// cycle-count timer). Build with MEMORY_RESPONDER_TIMER_EN defined or not;
// the bench follows the same macro.
module tb_memory_responder;

  localparam int          AW        = 12;
  localparam int          RAM_DEPTH = 1 << AW;
  localparam logic [31:0] MB        = 32'h8000_0000;
`ifdef MEMORY_RESPONDER_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] leds;
  logic       illegal_access;

  memory_responder_if bus();

  memory_responder #(
    .RAM_ADDR_WIDTH(AW),
    .MMIO_BASE(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .leds(leds),
    .illegal_access(illegal_access)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_ram   [RAM_DEPTH];
  bit          m_known [RAM_DEPTH];
  logic [7:0]  m_leds;
  bit          m_flag;
  logic [31:0] m_timer;
  logic [31:0] m_latch;

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Entered and left at a falling edge: drive one access, predict its effect,
  // clock it, then check outputs.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] data,
                               input logic we, output logic [7:0] observed);
    logic [7:0] exp_read;
    bit         read_known;
    bit         in_ram;
    bit         in_mmio;
    int         off;
    bus.address      = addr;
    bus.write_data   = data;
    bus.write_enable = we;
    in_ram     = addr < RAM_DEPTH;
    in_mmio    = addr[31:4] == MB[31:4];
    off        = int'(addr[3:0]);
    read_known = 1'b1;
    exp_read   = 8'h00;
    if (in_ram) begin
      read_known = m_known[addr[AW-1:0]];
      exp_read   = m_ram[addr[AW-1:0]];
    end else if (in_mmio) begin
      if (off == 0)                                exp_read = m_leds;
      else if (off == 8)                           exp_read = {7'd0, m_flag};
      else if (TIMER_EN && off == 4)               exp_read = m_timer[7:0];
      else if (TIMER_EN && off >= 5 && off <= 7)   exp_read = 8'(m_latch >> (8 * (off - 4)));
    end
    if (in_mmio && off == 4) m_latch = m_timer;
    m_timer = m_timer + 32'd1;
    if (!in_ram && !in_mmio) m_flag = 1'b1;
    if (we) begin
      if (in_ram) begin
        m_ram[addr[AW-1:0]]   = data;
        m_known[addr[AW-1:0]] = 1'b1;
      end else if (in_mmio && off == 0) begin
        m_leds = data;
      end else if (in_mmio && off == 8 && data[0]) begin
        m_flag = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    observed = bus.read_data;
    if (read_known) checkOutput("read_data", {24'd0, bus.read_data}, {24'd0, exp_read});
    checkOutput("leds", {24'd0, leds}, {24'd0, m_leds});
    checkOutput("illegal_access", {31'd0, illegal_access}, {31'd0, m_flag});
    @(negedge clk);
  endtask

  // Asserts reset with an access in flight, checks the asynchronous clear,
  // holds for two rising edges and releases at a falling edge.
  task automatic applyReset(input logic [31:0] addr, input logic [7:0] data, input logic we);
    bus.address      = addr;
    bus.write_data   = data;
    bus.write_enable = we;
    rst = 1'b0;
    #1;
    checkOutput("reset_read_data", {24'd0, bus.read_data}, 32'd0);
    checkOutput("reset_leds", {24'd0, leds}, 32'd0);
    checkOutput("reset_illegal", {31'd0, illegal_access}, 32'd0);
    m_leds  = 8'h00;
    m_flag  = 1'b0;
    m_timer = 32'd0;
    m_latch = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0]  obs;
    logic [7:0]  b0, b1, b2, b3;
    logic [7:0]  old_byte;
    logic [31:0] addr;
    int          guard;
    bus.address      = 32'd0;
    bus.write_data   = 8'd0;
    bus.write_enable = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) m_known[i] = 1'b0;

    @(negedge clk);
    applyReset(32'd0, 8'd0, 1'b0);

    // Fill the working RAM region and the top byte
    for (int i = 0; i < 64; i++) applyStimulus(32'(i), 8'($urandom), 1'b1, obs);
    applyStimulus(32'h0000_0FFF, 8'($urandom), 1'b1, obs);

    // Write, read back, read-first on same-cycle write
    applyStimulus(32'h10, 8'hA5, 1'b1, obs);
    applyStimulus(32'h10, 8'h00, 1'b0, obs);
    checkOutput("ram_readback", {24'd0, obs}, 32'hA5);
    applyStimulus(32'h10, 8'h3C, 1'b1, obs);
    checkOutput("read_first_old", {24'd0, obs}, 32'hA5);
    applyStimulus(32'h10, 8'h00, 1'b0, obs);
    checkOutput("read_first_new", {24'd0, obs}, 32'h3C);

    // LED register and asynchronous reset with a RAM write in flight
    applyStimulus(MB, 8'h5A, 1'b1, obs);
    checkOutput("leds_after_write", {24'd0, leds}, 32'h5A);
    applyStimulus(MB, 8'h00, 1'b0, obs);
    checkOutput("led_readback", {24'd0, obs}, 32'h5A);
    old_byte = m_ram[32];
    applyReset(32'h20, ~old_byte, 1'b1);
    applyStimulus(32'h20, 8'h00, 1'b0, obs);
    checkOutput("reset_write_dropped", {24'd0, obs}, {24'd0, old_byte});

    // Illegal access, sticky flag, STATUS clear
    applyStimulus(32'h0000_2000, 8'h00, 1'b0, obs);
    checkOutput("illegal_read_zero", {24'd0, obs}, 32'h00);
    applyStimulus(MB + 32'h8, 8'h00, 1'b0, obs);
    checkOutput("status_read", {24'd0, obs}, 32'h01);
    applyStimulus(MB + 32'h8, 8'h00, 1'b1, obs);
    checkOutput("status_write0_keeps", {31'd0, illegal_access}, 32'd1);
    applyStimulus(MB + 32'h8, 8'h01, 1'b1, obs);
    checkOutput("status_write1_clears", {31'd0, illegal_access}, 32'd0);

    // Illegal write must leave RAM untouched
    applyStimulus(32'h4000_0000, 8'hFF, 1'b1, obs);
    applyStimulus(32'h0000_0000, 8'h00, 1'b0, obs);
    applyStimulus(32'h0000_0FFF, 8'h00, 1'b0, obs);
    applyStimulus(MB + 32'h8, 8'h01, 1'b1, obs);

    // Decode boundaries: first byte past RAM, just past/below the window
    applyStimulus(32'h0000_1000, 8'h77, 1'b1, obs);
    applyStimulus(MB + 32'h10, 8'h00, 1'b0, obs);
    applyStimulus(MB + 32'h8, 8'h01, 1'b1, obs);
    applyStimulus(MB - 32'h1, 8'h00, 1'b0, obs);
    applyStimulus(MB + 32'h8, 8'h01, 1'b1, obs);
    applyStimulus(MB + 32'hF, 8'h12, 1'b1, obs);

    // Coherent 32-bit timer read at timer value 100
    guard = 0;
    while (m_timer != 32'd100 && guard < 200) begin
      applyStimulus(32'd0, 8'd0, 1'b0, obs);
      guard++;
    end
    checkOutput("timer_reach_100", m_timer, 32'd100);
    applyStimulus(MB + 32'h4, 8'h00, 1'b0, b0);
    applyStimulus(MB + 32'h5, 8'hEE, 1'b1, b1);
    applyStimulus(MB + 32'h6, 8'h00, 1'b0, b2);
    applyStimulus(MB + 32'h7, 8'h00, 1'b0, b3);
    checkOutput("timer_word_100", {b3, b2, b1, b0}, TIMER_EN ? 32'd100 : 32'd0);

    // Timer wrap from 0xFFFF_FFFE
`ifdef MEMORY_RESPONDER_TIMER_EN
    force dut.timer = 32'hFFFF_FFFE;
    #1;
    release dut.timer;
    m_timer = 32'hFFFF_FFFE;
`endif
    applyStimulus(32'd0, 8'd0, 1'b0, obs);
    applyStimulus(32'd0, 8'd0, 1'b0, obs);
    applyStimulus(MB + 32'h4, 8'h00, 1'b0, b0);
    applyStimulus(MB + 32'h5, 8'h00, 1'b0, b1);
    applyStimulus(MB + 32'h6, 8'h00, 1'b0, b2);
    applyStimulus(MB + 32'h7, 8'h00, 1'b0, b3);
    checkOutput("timer_word_wrap", {b3, b2, b1, b0}, 32'd0);

    // Randomized traffic over RAM, MMIO and illegal space
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: addr = 32'($urandom_range(0, 63));
        4:          addr = 32'h0000_0FFF;
        5, 6, 7:    addr = MB + 32'($urandom_range(0, 15));
        8:          addr = 32'h1000_0000 | 32'($urandom);
        default:    addr = MB + 32'h8;
      endcase
      applyStimulus(addr, 8'($urandom), 1'($urandom_range(0, 1)), obs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Byte-wide memory responder at the far end of the CPU's memory port: it receives the 32-bit byte address, write byte and write strobe, and returns one read byte. It holds a synchronous byte RAM, a small memory-mapped I/O window (LED register, free-running timer, status), and a sticky illegal-access flag. The CPU's memory controller sequences multi-byte accesses one byte per request on top of this block.

## Interface
- `RAM_ADDR_WIDTH`, 12: RAM size is 2^RAM_ADDR_WIDTH bytes, mapped at address 0.
- `MMIO_BASE`, 32'h8000_0000: base of the 16-byte MMIO window; bits [3:0] must be zero.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `address`  input  32  byte address from the CPU.
- `write_data`  input  8  byte to store.
- `write_enable`  input  1  store strobe; write happens at the rising edge where it is high.
- `read_data`  output  8  registered read byte for the address presented in the previous cycle.
- `leds`  output  8  contents of the LED register.
- `illegal_access`  output  1  sticky flag set by any access outside RAM or MMIO.

## Operation
- Address decode:
  - RAM: `address < 2^RAM_ADDR_WIDTH`.
  - MMIO: `address[31:4] == MMIO_BASE[31:4]`.
  - Everything else: illegal.
- RAM:
  - Byte write at the rising edge when `write_enable`=1.
  - Read first: a read and write to the same byte in the same cycle returns the old byte.
  - Contents are not reset.
- MMIO offsets (`address[3:0]`):
  - 0x0, LED: read/write; drives `leds`.
  - 0x4, TIMER0: read-only. A read returns live `timer[7:0]` and snapshots the full 32-bit timer into `timer_latch` at the same edge.
  - 0x5–0x7, TIMER1–3: read-only; return `timer_latch[15:8]`, `[23:16]`, `[31:24]`. This gives a coherent little-endian 32-bit read when the CPU reads offsets 4,5,6,7 in order.
  - 0x8, STATUS: bit0 = `illegal_access`, bits 7:1 read 0. Writing with `write_data[0]`=1 clears the flag; writing 0 has no effect.
  - Any other offset reads 0x00. Writes to it, or to TIMER0–3, are ignored and are not illegal.
- Illegal address:
  - Reads return 0x00 and writes are dropped.
  - `illegal_access` is set at the edge and stays set until cleared through STATUS or by reset.
- Timer:
  - 32-bit up-counter, +1 every clock.
  - Wraps 0xFFFF_FFFF to 0x0000_0000.

## Timing
- Read latency is 1 cycle: `read_data` after edge N reflects `address` sampled at edge N, and holds until the next edge.
- `read_data` updates every cycle regardless of `write_enable`. During a write cycle it shows the pre-write value of the addressed location.
- LED and STATUS writes are visible on `leds`/`illegal_access` right after the write edge, and on `read_data` from the next read.
- Reset values (asserted asynchronously while `rst`=0):
  - `read_data`=0x00, `leds`=0x00, `illegal_access`=0.
  - `timer`=0, `timer_latch`=0.
- Reset mid-access: the in-flight read result is discarded (`read_data` forced to 0); an in-flight write does not occur.
- The timer counts from 0 starting with the first edge after `rst` rises.
- TIMER0 read: the returned low byte and the latched word come from the same pre-increment timer value.

## Configuration
- Macro `MEMORY_RESPONDER_TIMER_EN`.
  - Defined: the timer and `timer_latch` are built and offsets 0x4–0x7 behave as above.
  - Undefined: no timer or latch registers; offsets 0x4–0x7 read 0x00 and writes to them are ignored. All other behaviour is unchanged.

## Test plan
- Reset with `rst`=0, write 0xA5 to 0x0000_0010 → next-cycle read of 0x10 gives 0xA5. Same-cycle write 0x3C plus read of 0x10 → 0xA5, then 0x3C on the following read.
- Write 0x5A to `MMIO_BASE`+0 → `leds`=0x5A after that edge; read of offset 0 returns 0x5A. Assert `rst` → `leds`=0x00 immediately.
- Read 0x0000_2000 (RAM_ADDR_WIDTH=12) → `read_data`=0x00, `illegal_access`=1. Write 0x00 to STATUS → still 1. Write 0x01 to STATUS → 0. A read of STATUS before the clear returns 0x01.
- `MEMORY_RESPONDER_TIMER_EN` defined: read offsets 4,5,6,7 on consecutive cycles starting at cycle 100 after reset release → the bytes assemble to 100 (low byte 0x64, others 0x00), unaffected by the increments in between.
- Force timer to 0xFFFF_FFFE, run 2 cycles, read offsets 4–7 → 0x0000_0000. Without the macro the same sequence → all reads 0x00.
- Illegal write to 0x4000_0000 with `write_enable`=1 → no RAM byte changes (spot-check addresses 0x0 and 0xFFF) and the flag is set.
